// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch control for a combinational-read
// instruction memory. Runs from a start address, redirects through a small
// writable branch-target table (PC LUT), and honours stall/halt requests.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start, start_pc     begin execution at start_pc (accepted in IDLE/HALT)
//   stall               hold pc this cycle (any branch is dropped)
//   branch_taken/idx    redirect pc to lut[branch_idx] on the next edge
//   halt_req            stop fetching; enter HALT
//   lut_we/waddr/wdata  PC LUT write port, usable in any state
//   pc                  registered instruction address
//   fetch_valid         instruction at pc is issued this cycle (combinational)
//   running, done       FSM in RUN / HALT
//   fetch_count         saturating count of issued fetches since last start
module fetch_sequencer #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned LUT_DEPTH = 16,
  parameter int unsigned LUT_IDX_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_pc,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 halt_req,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc,
  output logic                 fetch_valid,
  output logic                 running,
  output logic                 done,
  output logic [CNT_W-1:0]     fetch_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_q [LUT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      // Reads in this cycle already saw the old entry; the write lands at the edge.
      if (lut_we) begin
        lut_q[lut_waddr] <= lut_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StRun;
          pc_d    = start_pc;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (!stall) begin
          // A stalled branch is dropped, not queued; upstream re-presents it.
          if (branch_taken) begin
            pc_d = lut_q[branch_idx];
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc          = pc_q;
  assign running     = (state_q == StRun);
  assign done        = (state_q == StHalt);
  assign fetch_valid = running & ~stall & ~halt_req;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  start_pc;
  logic        stall;
  logic        branch_taken;
  logic [3:0]  branch_idx;
  logic        halt_req;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [7:0]  lut_wdata;
  logic [7:0]  pc;
  logic        fetch_valid;
  logic        running;
  logic        done;
  logic [15:0] fetch_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .start_pc     (start_pc),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_idx   (branch_idx),
    .halt_req     (halt_req),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .running      (running),
    .done         (done),
    .fetch_count  (fetch_count)
  );

  typedef struct {
    logic        st;
    logic [7:0]  spc;
    logic        stl;
    logic        br;
    logic [3:0]  idx;
    logic        hlt;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        e_fv;   // fetch_valid during the cycle
    logic [7:0]  e_pc;   // remaining fields: after the edge
    logic        e_run;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [7:0] spc, input logic stl, input logic br,
                     input logic [3:0] idx, input logic hlt, input logic we,
                     input logic [3:0] wa, input logic [7:0] wd, input logic e_fv,
                     input logic [7:0] e_pc, input logic e_run, input logic e_done,
                     input logic [15:0] e_cnt);
    vec_t v;
    v = '{st, spc, stl, br, idx, hlt, we, wa, wd, e_fv, e_pc, e_run, e_done, e_cnt};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle_inputs();
    start = 0; start_pc = 0; stall = 0; branch_taken = 0; branch_idx = 0;
    halt_req = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  // Called at posedge+1: drive, check combinational output, take edge, check state.
  task automatic run_vec(input vec_t v, input int n);
    start = v.st; start_pc = v.spc; stall = v.stl; branch_taken = v.br;
    branch_idx = v.idx; halt_req = v.hlt; lut_we = v.we; lut_waddr = v.wa; lut_wdata = v.wd;
    #4;
    chk($sformatf("v%0d fetch_valid", n), 32'(fetch_valid), 32'(v.e_fv));
    @(posedge clk); #1;
    chk($sformatf("v%0d pc", n), 32'(pc), 32'(v.e_pc));
    chk($sformatf("v%0d running", n), 32'(running), 32'(v.e_run));
    chk($sformatf("v%0d done", n), 32'(done), 32'(v.e_done));
    chk($sformatf("v%0d fetch_count", n), 32'(fetch_count), 32'(v.e_cnt));
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    //  st spc    stl br idx hlt we wa wd     fv pc     run dn cnt
    add(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h02, 0, 8'h00, 0, 0, 0);   // lut[0]=2 in IDLE
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);   // start at 0
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h02, 1, 0, 2);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h03, 1, 0, 3);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h04, 1, 0, 4);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h05, 1, 0, 5);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 1, 8'h02, 1, 0, 6);   // branch at pc=5 -> 2
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h03, 1, 0, 7);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h03, 1, 0, 7);   // stall + branch x3
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h03, 1, 0, 7);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h03, 1, 0, 7);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h04, 1, 0, 8);   // branch was dropped
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h05, 1, 0, 9);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h06, 1, 0, 10);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h07, 1, 0, 11);
    add(0, 8'h00, 1, 1, 0, 1, 0, 0, 8'h00, 0, 8'h07, 0, 1, 11);  // halt beats stall/branch
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'h07, 0, 1, 11);  // HALT holds
    add(1, 8'h10, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h10, 1, 0, 0);   // restart at 0x10
    add(1, 8'h33, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 1);   // start ignored in RUN
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'h11, 0, 1, 1);
    add(1, 8'hFE, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'hFE, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'hFF, 1, 0, 1);
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 1, 8'h00, 1, 0, 2);   // wrap
    add(0, 8'h00, 0, 1, 3, 0, 1, 3, 8'h80, 1, 8'h00, 1, 0, 3);   // branch sees old lut[3]=0
    add(0, 8'h00, 0, 1, 3, 0, 0, 0, 8'h00, 1, 8'h80, 1, 0, 4);   // now sees new value
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'h80, 0, 1, 4);

    idle_inputs();
    reset = 1'b1;
    #12;
    chk("reset pc", 32'(pc), 32'h0);
    chk("reset fetch_valid", 32'(fetch_valid), 32'h0);
    chk("reset running", 32'(running), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset fetch_count", 32'(fetch_count), 32'h0);
    reset = 1'b0;
    edge1();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Mid-run asynchronous reset discards LUT contents and state.
    idle_inputs();
    lut_we = 1; lut_waddr = 1; lut_wdata = 8'h55;
    edge1();
    idle_inputs();
    start = 1; start_pc = 8'h40;
    edge1();
    start = 0;
    chk("pre-reset pc", 32'(pc), 32'h40);
    chk("pre-reset fetch_valid", 32'(fetch_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset pc", 32'(pc), 32'h0);
    chk("async reset fetch_valid", 32'(fetch_valid), 32'h0);
    chk("async reset running", 32'(running), 32'h0);
    chk("async reset done", 32'(done), 32'h0);
    chk("async reset fetch_count", 32'(fetch_count), 32'h0);
    #2 reset = 1'b0;
    start = 1; start_pc = 8'h20;
    edge1();
    start = 0; branch_taken = 1; branch_idx = 1;
    edge1();
    branch_taken = 0;
    chk("cleared lut[1] branch pc", 32'(pc), 32'h0);
    chk("cleared lut[1] fetch_count", 32'(fetch_count), 32'h1);

    // Counter saturation.
    halt_req = 1;
    edge1();
    halt_req = 0; start = 1; start_pc = 8'h00;
    edge1();
    start = 0;
    repeat (65540) @(posedge clk);
    #1;
    chk("saturated fetch_count", 32'(fetch_count), 32'hFFFF);
    chk("long-run pc", 32'(pc), 32'h04);
    chk("long-run running", 32'(running), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and fetch-control stage that drives the 8-bit address into the combinational-read instruction memory. It sequences execution from a start address, redirects the PC through a small writable branch-target lookup table (PC LUT), and honours stall and halt requests from decode/execute. It also reports run/done status and a fetch count to the testbench and top level.

## Interface
Parameters:
- PC_W, 8, PC and instruction-address width
- LUT_DEPTH, 16, number of PC LUT entries
- LUT_IDX_W, 4, LUT index width; must equal clog2(LUT_DEPTH)
- CNT_W, 16, fetch-counter width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin execution at start_pc; sampled in IDLE and HALT only
- start_pc  in  PC_W  first fetch address on start
- stall  in  1  hold PC this cycle
- branch_taken  in  1  redirect PC to lut[branch_idx]
- branch_idx  in  LUT_IDX_W  LUT entry selecting the branch target
- halt_req  in  1  decoder saw the "done" instruction; stop fetching
- lut_we  in  1  PC LUT write enable
- lut_waddr  in  LUT_IDX_W  PC LUT write index
- lut_wdata  in  PC_W  PC LUT write data
- pc  out  PC_W  instruction-memory address (registered)
- fetch_valid  out  1  the instruction at pc is being issued this cycle
- running  out  1  FSM is in RUN
- done  out  1  FSM is in HALT
- fetch_count  out  CNT_W  number of issued fetches since the last start

## Operation
- FSM states: IDLE, RUN, HALT. Reset forces IDLE.
- IDLE:
  - pc holds.
  - start=1: go to RUN, pc<=start_pc, fetch_count<=0.
- RUN, evaluated in this priority order each cycle:
  1. halt_req=1: go to HALT, pc holds. Wins over stall and branch_taken.
  2. stall=1: pc and fetch_count hold; branch_taken is ignored. Upstream must re-present the branch after the stall.
  3. branch_taken=1: pc<=lut[branch_idx].
  4. Otherwise: pc<=pc+1, modulo 2^PC_W, so 255 wraps to 0 silently.
- fetch_valid = running & ~stall & ~halt_req.
- fetch_count increments on every cycle where fetch_valid=1 and saturates at all-ones.
- HALT:
  - done=1; pc and fetch_count hold.
  - start=1: go to RUN, pc<=start_pc, fetch_count<=0, done deasserts.
- start is ignored while in RUN.
- PC LUT:
  - LUT_DEPTH x PC_W registers; writable in any state.
  - A write takes effect at the clock edge.
  - A branch reading the entry being written in the same cycle uses the old contents.
- Reset:
  - Asynchronous; clears every LUT entry to 0.
  - Reset asserted mid-run aborts immediately, with no pending redirect surviving.

## Timing
- Reset values: pc=0, fetch_valid=0, running=0, done=0, fetch_count=0, FSM=IDLE, LUT all 0.
- pc, running, done and fetch_count are registered.
- fetch_valid is combinational from state, stall and halt_req.
- Instruction memory reads combinationally, so the instruction at pc is available in the same cycle.
- Branch penalty is zero: a branch_taken presented while pc=A makes pc equal the target on the next edge. There is no delay slot.
- start to first fetch: 1 cycle. pc=start_pc and running=1 after the edge that samples start.
- halt_req to done=1: 1 edge. fetch_valid drops combinationally in the halt_req cycle.

## Test plan
- Reset, then start with start_pc=0 and no stall/branch for 5 cycles -> pc sequence 0,1,2,3,4; fetch_count=5; fetch_valid=1 throughout.
- Write lut[0]=2, start at 0, assert branch_taken with branch_idx=0 while pc=5 -> next pc=2; fetch_count continues counting; a following cycle without branch gives pc=3.
- Stall at pc=3 for 3 cycles with branch_taken also high -> pc stays 3 and fetch_count is frozen; after stall release pc=4, so the branch was ignored.
- halt_req with stall and branch_taken all asserted at pc=7 -> next edge done=1, running=0, pc=7; later start with start_pc=0x10 -> pc=0x10, done=0, fetch_count=0.
- Start at 0xFE, run 3 cycles -> pc 0xFE,0xFF,0x00 (wrap); lut_we to entry 3 in the same cycle as a branch with branch_idx=3 -> branch uses the old value 0.
- Assert reset mid-RUN at pc=0x40 after writing lut[1]=0x55 -> all outputs are at reset values immediately (asynchronously); lut[1] reads back as 0 on the next branch.
